// File: rtl/fifo_pkg.sv
// Shared encodings and defaults for the FIFO burst master.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 4;
    localparam int DEF_LEN_WIDTH  = 4;
    localparam int DEF_TIMEOUT    = 15;
    localparam int FIFO_DEPTH     = 8;

    localparam logic DIR_WRITE = 1'b0;
    localparam logic DIR_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ISSUE,
        ST_WR_WAIT,
        ST_WAIT_SPACE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_WAIT_DATA,
        ST_DONE,
        ST_ERROR
    } state_t;

    function automatic logic is_wait_state(input state_t s);
        return (s == ST_WAIT_SPACE) || (s == ST_WAIT_DATA);
    endfunction

endpackage

// File: rtl/fifo_master_ns.sv
// Next-state logic for the burst master: issue/response handshake with bounded waits.
module fifo_master_ns
    import fifo_pkg::*;
#(
    parameter int LEN_WIDTH = DEF_LEN_WIDTH,
    parameter int TMR_WIDTH = 4,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  state_t               state,
    input  logic                 cmd_accept,
    input  logic                 cmd_dir,
    input  logic                 cmd_len_zero,
    input  logic                 space_avail,
    input  logic                 data_avail,
    input  logic                 wr_ack,
    input  logic                 wr_err,
    input  logic                 rd_ack,
    input  logic                 rd_err,
    input  logic [LEN_WIDTH-1:0] remaining,
    input  logic [TMR_WIDTH-1:0] timer,
    output state_t               next_state
);

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (cmd_accept) begin
                    if (cmd_len_zero)            next_state = ST_DONE;
                    else if (cmd_dir == DIR_READ) next_state = ST_RD_ISSUE;
                    else                          next_state = ST_WR_ISSUE;
                end
            end
            ST_WR_ISSUE:   next_state = space_avail ? ST_WR_WAIT : ST_WAIT_SPACE;
            ST_WR_WAIT: begin
                // An error response wins even if ack is also raised.
                if (wr_err || !wr_ack)                   next_state = ST_ERROR;
                else if (remaining == LEN_WIDTH'(1))     next_state = ST_DONE;
                else                                     next_state = ST_WR_ISSUE;
            end
            ST_WAIT_SPACE: begin
                if (space_avail)                         next_state = ST_WR_ISSUE;
                else if (timer == TMR_WIDTH'(TIMEOUT))   next_state = ST_ERROR;
            end
            ST_RD_ISSUE:   next_state = data_avail ? ST_RD_WAIT : ST_WAIT_DATA;
            ST_RD_WAIT: begin
                if (rd_err || !rd_ack)                   next_state = ST_ERROR;
                else if (remaining == LEN_WIDTH'(1))     next_state = ST_DONE;
                else                                     next_state = ST_RD_ISSUE;
            end
            ST_WAIT_DATA: begin
                if (data_avail)                          next_state = ST_RD_ISSUE;
                else if (timer == TMR_WIDTH'(TIMEOUT))   next_state = ST_ERROR;
            end
            ST_DONE, ST_ERROR: next_state = ST_IDLE;
            default:           next_state = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/fifo_burst_master.sv
// Burst initiator for an 8-deep FIFO: turns write-N / read-N commands into single-word
// FIFO accesses, never issuing one the FIFO would reject, and reports done/err/count.
module fifo_burst_master
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    output logic                  wr_data_req,
    output logic [DATA_WIDTH-1:0] rd_data_out,
    output logic                  rd_data_valid,
    output logic                  done,
    output logic                  err,
    output logic [LEN_WIDTH-1:0]  xfer_count,
    output logic                  fifo_wr_en,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic [CNT_WIDTH-1:0]  fifo_data_count,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    input  logic                  fifo_wr_ack,
    input  logic                  fifo_wr_err,
    input  logic                  fifo_rd_ack,
    input  logic                  fifo_rd_err
);

    localparam int TMR_WIDTH = $clog2(TIMEOUT + 1);

    state_t                 state;
    state_t                 next_state;
    logic [LEN_WIDTH-1:0]   remaining;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [TMR_WIDTH-1:0]   timer;
    logic                   cmd_accept;
    logic                   space_avail;
    logic                   data_avail;
    logic                   wr_ok;
    logic                   rd_ok;

    // Flag and occupancy must both agree before an access is issued.
    assign space_avail = !fifo_full  && (fifo_data_count < CNT_WIDTH'(FIFO_DEPTH));
    assign data_avail  = !fifo_empty && (fifo_data_count != '0);

    assign cmd_ready   = (state == ST_IDLE);
    assign cmd_accept  = cmd_valid && cmd_ready;
    assign fifo_wr_en  = (state == ST_WR_ISSUE) && space_avail;
    assign fifo_rd_en  = (state == ST_RD_ISSUE) && data_avail;
    assign wr_data_req = fifo_wr_en;
    assign fifo_din    = wr_data_in;
    assign done        = (state == ST_DONE) || (state == ST_ERROR);

    assign wr_ok = (state == ST_WR_WAIT) && fifo_wr_ack && !fifo_wr_err;
    assign rd_ok = (state == ST_RD_WAIT) && fifo_rd_ack && !fifo_rd_err;

    fifo_master_ns #(
        .LEN_WIDTH (LEN_WIDTH),
        .TMR_WIDTH (TMR_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) u_ns (
        .state        (state),
        .cmd_accept   (cmd_accept),
        .cmd_dir      (cmd_dir),
        .cmd_len_zero (cmd_len == '0),
        .space_avail  (space_avail),
        .data_avail   (data_avail),
        .wr_ack       (fifo_wr_ack),
        .wr_err       (fifo_wr_err),
        .rd_ack       (fifo_rd_ack),
        .rd_err       (fifo_rd_err),
        .remaining    (remaining),
        .timer        (timer),
        .next_state   (next_state)
    );

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining     <= '0;
            len_q         <= '0;
            timer         <= '0;
            xfer_count    <= '0;
            err           <= 1'b0;
            rd_data_out   <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= 1'b0;
            // Timer counts cycles spent in the upcoming wait state, so it reads 1 on entry.
            timer <= is_wait_state(next_state) ? timer + 1'b1 : '0;
            if (cmd_accept) begin
                remaining  <= cmd_len;
                len_q      <= cmd_len;
                xfer_count <= '0;
                err        <= 1'b0;
            end
            if (wr_ok || rd_ok) begin
                remaining <= remaining - 1'b1;
                if (xfer_count != len_q) xfer_count <= xfer_count + 1'b1;
            end
            if (rd_ok) begin
                rd_data_out   <= fifo_dout;
                rd_data_valid <= 1'b1;
            end
            if (next_state == ST_ERROR && state != ST_ERROR) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_burst_master.sv
// Directed bench for fifo_burst_master with a behavioural 8-deep FIFO responder.
module tb_fifo_burst_master;
    import fifo_pkg::*;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_dir = 1'b0;
    logic [LW-1:0] cmd_len = '0;
    logic [DW-1:0] wr_data_in;
    logic          wr_data_req;
    logic [DW-1:0] rd_data_out;
    logic          rd_data_valid;
    logic          done;
    logic          err;
    logic [LW-1:0] xfer_count;
    logic          fifo_wr_en;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_din;
    logic [DW-1:0] fifo_dout = '0;
    logic [CW-1:0] fifo_data_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_wr_ack = 1'b0;
    logic          fifo_wr_err = 1'b0;
    logic          fifo_rd_ack = 1'b0;
    logic          fifo_rd_err = 1'b0;

    always #5 clk = ~clk;

    fifo_burst_master dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_dir         (cmd_dir),
        .cmd_len         (cmd_len),
        .wr_data_in      (wr_data_in),
        .wr_data_req     (wr_data_req),
        .rd_data_out     (rd_data_out),
        .rd_data_valid   (rd_data_valid),
        .done            (done),
        .err             (err),
        .xfer_count      (xfer_count),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_din        (fifo_din),
        .fifo_dout       (fifo_dout),
        .fifo_data_count (fifo_data_count),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .fifo_wr_ack     (fifo_wr_ack),
        .fifo_wr_err     (fifo_wr_err),
        .fifo_rd_ack     (fifo_rd_ack),
        .fifo_rd_err     (fifo_rd_err)
    );

    // ---------------- word source ----------------
    int src_idx = 0;
    assign wr_data_in = 32'hA000_0000 + DW'(src_idx);
    always @(posedge clk) if (wr_data_req) src_idx <= src_idx + 1;

    // ---------------- FIFO model ----------------
    logic [DW-1:0] mdl_q[$];
    int            fcount = 0;
    int            wr_seen = 0;
    int            wr_err_at = 0;
    logic          tb_clear = 1'b0;
    logic          tb_push = 1'b0;
    logic [DW-1:0] tb_push_data = '0;

    assign fifo_data_count = CW'(fcount);
    assign fifo_full       = (fcount == 8);
    assign fifo_empty      = (fcount == 0);

    always @(posedge clk) begin
        fifo_wr_ack <= 1'b0;
        fifo_wr_err <= 1'b0;
        fifo_rd_ack <= 1'b0;
        fifo_rd_err <= 1'b0;
        if (tb_clear) begin
            mdl_q.delete();
            wr_seen = 0;
        end else if (tb_push) begin
            mdl_q.push_back(tb_push_data);
        end else if (fifo_wr_en && !fifo_rd_en) begin
            wr_seen = wr_seen + 1;
            if (wr_seen == wr_err_at || mdl_q.size() >= 8) fifo_wr_err <= 1'b1;
            else begin
                mdl_q.push_back(fifo_din);
                fifo_wr_ack <= 1'b1;
            end
        end else if (fifo_rd_en && !fifo_wr_en) begin
            if (mdl_q.size() == 0) fifo_rd_err <= 1'b1;
            else begin
                fifo_dout   <= mdl_q.pop_front();
                fifo_rd_ack <= 1'b1;
            end
        end
        fcount <= mdl_q.size();
    end

    // ---------------- monitor ----------------
    int            cyc = 0;
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    int            viol = 0;
    int            wr_cycles[$];
    logic [DW-1:0] rd_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_wr_en) begin
            wr_cnt = wr_cnt + 1;
            wr_cycles.push_back(cyc);
        end
        if (fifo_rd_en) rd_cnt = rd_cnt + 1;
        if (fifo_wr_en && fifo_full)  viol = viol + 1;
        if (fifo_rd_en && fifo_empty) viol = viol + 1;
        if (fifo_wr_en && fifo_rd_en) viol = viol + 1;
        if (rd_data_valid) rd_q.push_back(rd_data_out);
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int failures = 0;

    // ---------------- helpers ----------------
    task automatic clear_fifo();
        @(negedge clk) tb_clear = 1'b1;
        @(posedge clk);
        #1 tb_clear = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        @(negedge clk);
        tb_push = 1'b1;
        tb_push_data = d;
        @(posedge clk);
        #1 tb_push = 1'b0;
    endtask

    task automatic send_cmd(input logic dir, input logic [LW-1:0] len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir = dir;
        cmd_len = len;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output logic got, output logic e, output logic [LW-1:0] xc,
                             output int dcyc, input int budget);
        got = 1'b0;
        e = 1'b0;
        xc = '0;
        dcyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                e = err;
                xc = xfer_count;
                dcyc = cyc;
                break;
            end
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        end
        checks++;
        if ({done, err, rd_data_valid, fifo_wr_en, fifo_rd_en, wr_data_req} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 000000",
                     {done, err, rd_data_valid, fifo_wr_en, fifo_rd_en, wr_data_req});
        end
        checks++;
        if (xfer_count !== '0 || rd_data_out !== '0) begin
            failures++;
            $display("FAIL reset_regs: xfer_count %0d rd_data_out %h expected 0 0", xfer_count, rd_data_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_write_burst();
        logic got, e;
        logic [LW-1:0] xc;
        int dc, wb, sb;
        clear_fifo();
        wb = wr_cycles.size();
        sb = src_idx;
        send_cmd(DIR_WRITE, 4'd3);
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL wr_busy_ready: got %b expected 0", cmd_ready);
        end
        wait_done(got, e, xc, dc, 40);
        checks++;
        if (got !== 1'b1 || e !== 1'b0 || xc !== 4'd3) begin
            failures++;
            $display("FAIL wr_done: done %b err %b xfer %0d expected 1 0 3", got, e, xc);
        end
        checks++;
        if (wr_cycles.size() - wb != 3) begin
            failures++;
            $display("FAIL wr_pulses: got %0d expected 3", wr_cycles.size() - wb);
        end else begin
            checks++;
            if (wr_cycles[wb+1] - wr_cycles[wb] != 2 || wr_cycles[wb+2] - wr_cycles[wb+1] != 2
                || dc - wr_cycles[wb+2] != 2) begin
                failures++;
                $display("FAIL wr_spacing: gaps %0d %0d done_gap %0d expected 2 2 2",
                         wr_cycles[wb+1] - wr_cycles[wb], wr_cycles[wb+2] - wr_cycles[wb+1],
                         dc - wr_cycles[wb+2]);
            end
        end
        checks++;
        if (mdl_q.size() != 3) begin
            failures++;
            $display("FAIL wr_fifo_len: got %0d expected 3", mdl_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (mdl_q[i] !== 32'hA000_0000 + DW'(sb + i)) begin
                    failures++;
                    $display("FAIL wr_data%0d: got %h expected %h", i, mdl_q[i], 32'hA000_0000 + DW'(sb + i));
                end
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (xfer_count !== 4'd3 || done !== 1'b0) begin
            failures++;
            $display("FAIL wr_hold: xfer %0d done %b expected 3 0", xfer_count, done);
        end
    endtask

    task automatic test_read_burst();
        logic got, e;
        logic [LW-1:0] xc;
        int dc, rb;
        clear_fifo();
        push_word(32'h1111_AAAA);
        push_word(32'h2222_BBBB);
        rb = rd_q.size();
        send_cmd(DIR_READ, 4'd2);
        wait_done(got, e, xc, dc, 40);
        checks++;
        if (got !== 1'b1 || e !== 1'b0 || xc !== 4'd2) begin
            failures++;
            $display("FAIL rd_done: done %b err %b xfer %0d expected 1 0 2", got, e, xc);
        end
        checks++;
        if (rd_q.size() - rb != 2) begin
            failures++;
            $display("FAIL rd_count: got %0d expected 2", rd_q.size() - rb);
        end else begin
            checks++;
            if (rd_q[rb] !== 32'h1111_AAAA || rd_q[rb+1] !== 32'h2222_BBBB) begin
                failures++;
                $display("FAIL rd_data: got %h %h expected 1111aaaa 2222bbbb", rd_q[rb], rd_q[rb+1]);
            end
        end
    endtask

    task automatic test_full_timeout();
        logic got, e;
        logic [LW-1:0] xc;
        int dc, wb, vb;
        clear_fifo();
        for (int i = 0; i < 7; i++) push_word(32'h7000_0000 + DW'(i));
        wb = wr_cycles.size();
        vb = viol;
        send_cmd(DIR_WRITE, 4'd4);
        wait_done(got, e, xc, dc, 60);
        checks++;
        if (got !== 1'b1 || e !== 1'b1 || xc !== 4'd1) begin
            failures++;
            $display("FAIL to_done: done %b err %b xfer %0d expected 1 1 1", got, e, xc);
        end
        checks++;
        if (wr_cycles.size() - wb != 1 || viol != vb) begin
            failures++;
            $display("FAIL to_writes: pulses %0d violations %0d expected 1 0", wr_cycles.size() - wb, viol - vb);
        end else begin
            // wr_en, WR_WAIT, WR_ISSUE, 15 x WAIT_SPACE, then ERROR.
            checks++;
            if (dc - wr_cycles[wb] != 18) begin
                failures++;
                $display("FAIL to_latency: got %0d expected 18", dc - wr_cycles[wb]);
            end
        end
    endtask

    task automatic test_read_wait_data();
        logic got, e;
        logic [LW-1:0] xc;
        int dc, rb, rdb, vb;
        clear_fifo();
        rb = rd_q.size();
        rdb = rd_cnt;
        vb = viol;
        send_cmd(DIR_READ, 4'd1);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (rd_cnt != rdb || done !== 1'b0) begin
            failures++;
            $display("FAIL wd_early: rd_en %0d done %b expected 0 0", rd_cnt - rdb, done);
        end
        push_word(32'hC0DE_C0DE);
        wait_done(got, e, xc, dc, 30);
        checks++;
        if (got !== 1'b1 || e !== 1'b0 || xc !== 4'd1 || rd_cnt - rdb != 1 || viol != vb) begin
            failures++;
            $display("FAIL wd_done: done %b err %b xfer %0d rd_en %0d viol %0d expected 1 0 1 1 0",
                     got, e, xc, rd_cnt - rdb, viol - vb);
        end
        checks++;
        if (rd_q.size() - rb != 1 || rd_q[rb] !== 32'hC0DE_C0DE) begin
            failures++;
            $display("FAIL wd_data: count %0d expected 1 data c0dec0de", rd_q.size() - rb);
        end
    endtask

    task automatic test_wr_err();
        logic got, e;
        logic [LW-1:0] xc;
        int dc, wb;
        clear_fifo();
        wr_err_at = 2;
        wb = wr_cnt;
        send_cmd(DIR_WRITE, 4'd3);
        wait_done(got, e, xc, dc, 40);
        wr_err_at = 0;
        checks++;
        if (got !== 1'b1 || e !== 1'b1 || xc !== 4'd1) begin
            failures++;
            $display("FAIL werr_done: done %b err %b xfer %0d expected 1 1 1", got, e, xc);
        end
        checks++;
        if (wr_cnt - wb != 2 || mdl_q.size() != 1) begin
            failures++;
            $display("FAIL werr_access: wr_en %0d fifo %0d expected 2 1", wr_cnt - wb, mdl_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        logic seen;
        int rb, wb, rdb;
        clear_fifo();
        push_word(32'hDDDD_0001);
        send_cmd(DIR_READ, 4'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rst_issue: rd_en got 0 expected 1");
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || {done, err, rd_data_valid, fifo_rd_en, fifo_wr_en} !== 5'b0
            || xfer_count !== '0) begin
            failures++;
            $display("FAIL rst_outputs: ready %b strobes %b xfer %0d expected 1 00000 0",
                     cmd_ready, {done, err, rd_data_valid, fifo_rd_en, fifo_wr_en}, xfer_count);
        end
        @(negedge clk);
        reset = 1'b0;
        rb = rd_q.size();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (rd_q.size() != rb || done !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_ignore: valid %0d done %b ready %b expected 0 0 1",
                     rd_q.size() - rb, done, cmd_ready);
        end
        wb = wr_cnt;
        rdb = rd_cnt;
        send_cmd(DIR_WRITE, 4'd0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || xfer_count !== '0) begin
            failures++;
            $display("FAIL zero_done: done %b err %b xfer %0d expected 1 0 0", done, err, xfer_count);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (wr_cnt != wb || rd_cnt != rdb || done !== 1'b0) begin
            failures++;
            $display("FAIL zero_access: wr %0d rd %0d done %b expected 0 0 0", wr_cnt - wb, rd_cnt - rdb, done);
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_full_timeout();
        test_read_wait_data();
        test_wr_err();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
